// File: rtl/frame_window_reader.sv
// frame_window_reader: walks one 3-row band of the line frame buffer left to
// right and hands 3x3 pixel windows to the edge-detection kernel over a
// valid/ready handshake. The band's top row is supplied per pass, and rows
// wrap modulo 3 from there.
module frame_window_reader #(
  parameter int P_COLUMNS     = 640,
  parameter int P_PIXEL_DEPTH = 24
) (
  input  logic                         I_CLK,
  input  logic                         I_RESET,
  input  logic                         I_START,
  input  logic [1:0]                   I_TOP_ROW,
  output logic [$clog2(P_COLUMNS)-1:0] O_FB_COLUMN,
  output logic [1:0]                   O_FB_ROW,
  output logic                         O_FB_READ_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0]     I_FB_PIXEL,
  output logic [9*P_PIXEL_DEPTH-1:0]   O_WINDOW,
  output logic                         O_VALID,
  input  logic                         I_READY,
  output logic                         O_BUSY,
  output logic                         O_DONE
);

  localparam int CW = $clog2(P_COLUMNS);
  localparam int PD = P_PIXEL_DEPTH;
  localparam logic [CW-1:0] LAST_COL = CW'(P_COLUMNS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_PRESENT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      top_q, top_d;
  logic [1:0]      k_q, k_d;
  logic [1:0]      loaded_q, loaded_d;
  logic [CW-1:0]   col_q, col_d;
  logic [PD-1:0]   slot0_q, slot0_d;
  logic [PD-1:0]   slot1_q, slot1_d;
  logic [9*PD-1:0] window_q, window_d;
  logic [9*PD-1:0] window_shift;
  logic [3*PD-1:0] new_col;
  logic [2:0]      row_sum;
  logic [1:0]      fb_row;

  // Physical row for read k of the current column: (top + k) mod 3.
  assign row_sum = {1'b0, top_q} + {1'b0, k_q};
  assign fb_row  = (row_sum >= 3'd3) ? 2'(row_sum - 3'd3) : 2'(row_sum);

  // Slot 2 is not registered: it arrives on the bus during the capture cycle.
  assign new_col = {I_FB_PIXEL, slot1_q, slot0_q};

  // Window shifted one column left with the freshly read column on the right.
  for (genvar gi = 0; gi < 3; gi++) begin : g_shift
    assign window_shift[(3*gi+0)*PD +: PD] = window_q[(3*gi+1)*PD +: PD];
    assign window_shift[(3*gi+1)*PD +: PD] = window_q[(3*gi+2)*PD +: PD];
    assign window_shift[(3*gi+2)*PD +: PD] = new_col[gi*PD +: PD];
  end

  assign O_WINDOW = window_q;
  assign O_BUSY   = (state_q != S_IDLE);

  // Next-state, datapath updates and frame buffer / handshake outputs.
  always_comb begin
    state_d          = state_q;
    top_d            = top_q;
    k_d              = k_q;
    loaded_d         = loaded_q;
    col_d            = col_q;
    slot0_d          = slot0_q;
    slot1_d          = slot1_q;
    window_d         = window_q;
    O_FB_READ_ENABLE = 1'b0;
    O_FB_COLUMN      = '0;
    O_FB_ROW         = '0;
    O_VALID          = 1'b0;
    O_DONE           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          top_d    = (I_TOP_ROW == 2'd3) ? 2'd0 : I_TOP_ROW;
          col_d    = '0;
          loaded_d = 2'd0;
          k_d      = 2'd0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        O_FB_READ_ENABLE = 1'b1;
        O_FB_COLUMN      = col_q;
        O_FB_ROW         = fb_row;
        // Data on the bus now belongs to the read issued one cycle earlier.
        if (k_q == 2'd1) slot0_d = I_FB_PIXEL;
        if (k_q == 2'd2) slot1_d = I_FB_PIXEL;
        if (k_q == 2'd2) begin
          k_d     = 2'd0;
          state_d = S_CAPTURE;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_CAPTURE: begin
        window_d = window_shift;
        loaded_d = (loaded_q == 2'd3) ? 2'd3 : loaded_q + 2'd1;
        if (loaded_q >= 2'd2) begin
          state_d = S_PRESENT;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = S_READ;
        end
      end
      S_PRESENT: begin
        O_VALID = 1'b1;
        if (I_READY) begin
          if (col_q == LAST_COL) begin
            O_DONE  = 1'b1;
            state_d = S_IDLE;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including the window.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q  <= S_IDLE;
      top_q    <= 2'd0;
      k_q      <= 2'd0;
      loaded_q <= 2'd0;
      col_q    <= '0;
      slot0_q  <= '0;
      slot1_q  <= '0;
      window_q <= '0;
    end else begin
      state_q  <= state_d;
      top_q    <= top_d;
      k_q      <= k_d;
      loaded_q <= loaded_d;
      col_q    <= col_d;
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      window_q <= window_d;
    end
  end

endmodule

// File: tb/tb_frame_window_reader.sv
// Bench for frame_window_reader: a frame buffer memory model answers reads,
// expected windows and read addresses are queued when a pass is started,
// and a negedge monitor pops and compares them as the DUT presents them.
module tb_frame_window_reader;

  localparam int COLS = 640;
  localparam int PD   = 24;
  localparam int CW   = $clog2(COLS);
  localparam int WW   = 9 * PD;

  logic          I_CLK = 1'b0;
  logic          I_RESET = 1'b1;
  logic          I_START = 1'b1;
  logic [1:0]    I_TOP_ROW = 2'd0;
  logic [CW-1:0] O_FB_COLUMN;
  logic [1:0]    O_FB_ROW;
  logic          O_FB_READ_ENABLE;
  logic [PD-1:0] I_FB_PIXEL = '0;
  logic [WW-1:0] O_WINDOW;
  logic          O_VALID;
  logic          I_READY = 1'b1;
  logic          O_BUSY;
  logic          O_DONE;

  frame_window_reader #(.P_COLUMNS(COLS), .P_PIXEL_DEPTH(PD)) dut (
    .I_CLK(I_CLK), .I_RESET(I_RESET), .I_START(I_START), .I_TOP_ROW(I_TOP_ROW),
    .O_FB_COLUMN(O_FB_COLUMN), .O_FB_ROW(O_FB_ROW), .O_FB_READ_ENABLE(O_FB_READ_ENABLE),
    .I_FB_PIXEL(I_FB_PIXEL), .O_WINDOW(O_WINDOW), .O_VALID(O_VALID), .I_READY(I_READY),
    .O_BUSY(O_BUSY), .O_DONE(O_DONE)
  );

  initial forever #5 I_CLK = ~I_CLK;

  typedef struct {
    logic [WW-1:0] w;
    bit            last;
  } win_t;
  typedef struct {
    int col;
    int row;
  } rd_t;

  logic [PD-1:0] mem [3][COLS];
  win_t exp_win[$];
  rd_t  exp_rd[$];

  int errors = 0;
  int checks = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  int ready_mode = 0;

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  // Frame buffer: registered read, data valid one cycle after the strobe.
  always @(posedge I_CLK) begin
    if (O_FB_READ_ENABLE && O_FB_ROW < 2'd3 && int'(O_FB_COLUMN) < COLS)
      I_FB_PIXEL <= mem[O_FB_ROW][O_FB_COLUMN];
  end

  task automatic fill_formula();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < COLS; c++)
        mem[r][c] = PD'(r * 1024 + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < COLS; c++)
        mem[r][c] = PD'($urandom);
  endtask

  // Reference: a band pass reads every column top-down from row T (wrapping
  // mod 3) and yields COLS-2 windows, window n spanning columns n..n+2.
  task automatic push_pass(input logic [1:0] tin);
    int t;
    win_t e;
    rd_t rd;
    t = (tin == 2'd3) ? 0 : int'(tin);
    for (int c = 0; c < COLS; c++)
      for (int k = 0; k < 3; k++) begin
        rd.col = c;
        rd.row = (t + k) % 3;
        exp_rd.push_back(rd);
      end
    for (int n = 0; n < COLS - 2; n++) begin
      e.w = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.w[(3*r+c)*PD +: PD] = mem[(t + r) % 3][n + c];
      e.last = (n == COLS - 3);
      exp_win.push_back(e);
    end
  endtask

  // Ready driver: tied high, random, or a 5-cycle stall on window 10.
  initial begin
    int stall;
    stall = 0;
    forever begin
      @(posedge I_CLK);
      #1;
      if (win_cnt == 0) stall = 0;
      case (ready_mode)
        0: I_READY = 1'b1;
        1: I_READY = 1'($urandom_range(0, 1));
        default: begin
          if (O_VALID && win_cnt == 10 && stall < 5) begin
            I_READY = 1'b0;
            stall++;
          end else begin
            I_READY = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: compares reads and accepted windows against the queues.
  initial begin
    int cyc;
    int acc_cyc;
    bit prev_valid;
    bit prev_hs;
    bit have_acc;
    logic [WW-1:0] held_w;
    win_t ew;
    rd_t er;
    cyc = 0; acc_cyc = 0; prev_valid = 0; prev_hs = 0; have_acc = 0; held_w = '0;
    forever begin
      @(negedge I_CLK);
      cyc++;
      if (I_RESET) begin
        prev_valid = 0;
        prev_hs = 0;
        have_acc = 0;
      end else begin
        if (I_START && !O_BUSY) begin
          win_cnt = 0;
          done_cnt = 0;
          have_acc = 0;
        end
        if (O_FB_READ_ENABLE) begin
          if (exp_rd.size() == 0) begin
            fail_event("unexpected_read");
          end else begin
            er = exp_rd.pop_front();
            check_i("read_col", int'(O_FB_COLUMN), er.col);
            check_i("read_row", int'(O_FB_ROW), er.row);
          end
        end
        if (O_VALID) begin
          check_i("no_read_while_valid", int'(O_FB_READ_ENABLE), 0);
          // Accepted at the edge after the handshake sample; next valid 4 edges later.
          if (!prev_valid) begin
            if (have_acc) check_i("window_gap", cyc - acc_cyc, 5);
          end else if (!prev_hs) begin
            check_w("window_held", O_WINDOW, held_w);
          end
          held_w = O_WINDOW;
          if (I_READY) begin
            if (exp_win.size() == 0) begin
              fail_event("unexpected_window");
            end else begin
              ew = exp_win.pop_front();
              check_w("window", O_WINDOW, ew.w);
              check_i("done_on_last", int'(O_DONE), int'(ew.last));
            end
            win_cnt++;
            if (O_DONE) begin
              done_cnt++;
              have_acc = 0;
            end else begin
              have_acc = 1;
              acc_cyc = cyc;
            end
          end
        end
        if (O_DONE && !(O_VALID && I_READY)) fail_event("spurious_done");
        prev_valid = O_VALID;
        prev_hs = O_VALID && I_READY;
      end
    end
  end

  task automatic run_pass(input logic [1:0] top, input int mode, input bit poke);
    int lat;
    int n;
    bit poked;
    ready_mode = mode;
    push_pass(top);
    @(posedge I_CLK); #1;
    I_TOP_ROW = top;
    I_START = 1'b1;
    @(posedge I_CLK); #1;
    I_START = 1'b0;
    lat = 0;
    while (!O_VALID && lat < 40) begin
      @(posedge I_CLK); #1;
      lat++;
    end
    check_i("first_latency", lat, 12);
    n = 0;
    poked = 0;
    while (done_cnt == 0 && n < 30000) begin
      @(posedge I_CLK); #1;
      n++;
      if (poke && !poked && win_cnt == 5) begin
        I_TOP_ROW = 2'd1;
        I_START = 1'b1;
        @(posedge I_CLK); #1;
        I_START = 1'b0;
        poked = 1;
      end
    end
    repeat (3) @(posedge I_CLK);
    #1;
    check_i("done_count", done_cnt, 1);
    check_i("window_count", win_cnt, COLS - 2);
    check_i("windows_left", exp_win.size(), 0);
    check_i("reads_left", exp_rd.size(), 0);
    check_i("idle_after_pass", int'(O_BUSY), 0);
  endtask

  initial begin
    bit bad;
    fill_formula();
    // Reset held two cycles with start asserted.
    repeat (2) @(posedge I_CLK);
    #1;
    check_i("rst_valid", int'(O_VALID), 0);
    check_i("rst_busy", int'(O_BUSY), 0);
    check_i("rst_done", int'(O_DONE), 0);
    check_i("rst_fb_re", int'(O_FB_READ_ENABLE), 0);
    check_i("rst_fb_col", int'(O_FB_COLUMN), 0);
    check_i("rst_fb_row", int'(O_FB_ROW), 0);
    check_w("rst_window", O_WINDOW, '0);
    I_RESET = 1'b0;
    I_START = 1'b0;
    @(posedge I_CLK); #1;
    check_i("idle_busy", int'(O_BUSY), 0);

    run_pass(2'd0, 0, 1'b0);          // full band, ready tied high
    run_pass(2'd2, 1, 1'b0);          // row wrap, random ready
    fill_random();
    run_pass(2'd3, 1, 1'b0);          // top row 3 acts as 0
    fill_random();
    run_pass(2'd0, 2, 1'b1);          // stall on window 10, start pulse on window 5

    // Reset in the middle of a pass.
    fill_random();
    ready_mode = 1;
    push_pass(2'd1);
    @(posedge I_CLK); #1;
    I_TOP_ROW = 2'd1;
    I_START = 1'b1;
    @(posedge I_CLK); #1;
    I_START = 1'b0;
    repeat (200) @(posedge I_CLK);
    #1;
    I_RESET = 1'b1;
    exp_win.delete();
    exp_rd.delete();
    @(posedge I_CLK); #1;
    I_RESET = 1'b0;
    check_i("midrst_busy", int'(O_BUSY), 0);
    check_w("midrst_window", O_WINDOW, '0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (O_VALID || O_DONE || O_BUSY || O_FB_READ_ENABLE) bad = 1;
      @(posedge I_CLK); #1;
    end
    check_i("midrst_quiet", int'(bad), 0);

    fill_random();
    run_pass(2'd1, 0, 1'b0);          // recovery after reset

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
